mem_bus_arbiter: RTL and testbench

- Shares one OBI-style memory port (req/gnt/rvalid) between the instruction-fetch port and the load/store data port of the core.
- Arbitrates requests and holds the selection stable while a handshake is pending.
- Tracks outstanding transactions in an in-order owner FIFO and routes each response (rvalid/rdata/err) back to the requester that issued it.
- Sits between fetch/LSU and the memory interconnect.

---
 rtl/mem_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one OBI-style memory port between instruction fetch and LSU data port.
// Arbitrates, holds selection while a request is stalled, and routes responses in order.
module mem_bus_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          DATA_PRIORITY   = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   rstn,

    input  logic                                   instr_req_i,
    input  logic [31:0]                            instr_addr_i,
    output logic                                   instr_gnt_o,
    output logic                                   instr_rvalid_o,
    output logic [31:0]                            instr_rdata_o,
    output logic                                   instr_err_o,

    input  logic                                   data_req_i,
    input  logic                                   data_we_i,
    input  logic [3:0]                             data_be_i,
    input  logic [31:0]                            data_addr_i,
    input  logic [31:0]                            data_wdata_i,
    output logic                                   data_gnt_o,
    output logic                                   data_rvalid_o,
    output logic [31:0]                            data_rdata_o,
    output logic                                   data_err_o,

    output logic                                   mem_req_o,
    output logic                                   mem_we_o,
    output logic [3:0]                             mem_be_o,
    output logic [31:0]                            mem_addr_o,
    output logic [31:0]                            mem_wdata_o,
    input  logic                                   mem_gnt_i,
    input  logic                                   mem_rvalid_i,
    input  logic [31:0]                            mem_rdata_i,
    input  logic                                   mem_err_i,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   spurious_rsp_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic                       r_lock;
    logic                       r_sel;        // 1 = data port
    logic                       r_last_data;  // port granted most recently
    logic                       r_spurious;
    logic [CW-1:0]              r_count;
    logic [PW-1:0]              r_wptr;
    logic [PW-1:0]              r_rptr;
    logic [MAX_OUTSTANDING-1:0] r_owner;

    logic w_full;
    logic w_empty;
    logic w_lock_hold;
    logic w_sel;
    logic w_any_req;
    logic w_req;
    logic w_gnt;
    logic w_push;
    logic w_pop;
    logic w_head;

    assign w_full  = (r_count == CW'(MAX_OUTSTANDING));
    assign w_empty = (r_count == '0);

    // A locked port that drops its request releases the lock in the same cycle.
    assign w_lock_hold = r_lock && (r_sel ? data_req_i : instr_req_i);
    assign w_any_req   = instr_req_i | data_req_i;

    always_comb begin
        w_sel = data_req_i;
        if (w_lock_hold) begin
            w_sel = r_sel;
        end else if (instr_req_i && data_req_i) begin
            w_sel = DATA_PRIORITY ? 1'b1 : ~r_last_data;
        end
    end

    assign w_req = rstn & w_any_req & ~w_full;
    assign w_gnt = w_req & mem_gnt_i;

    always_comb begin
        mem_req_o   = w_req;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'hF;
        mem_addr_o  = instr_addr_i;
        mem_wdata_o = '0;
        if (w_sel) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    assign instr_gnt_o = w_gnt & ~w_sel;
    assign data_gnt_o  = w_gnt & w_sel;

    assign w_push = w_gnt;
    assign w_pop  = rstn & mem_rvalid_i & ~w_empty;
    assign w_head = r_owner[r_rptr];

    assign instr_rvalid_o = w_pop & ~w_head;
    assign data_rvalid_o  = w_pop & w_head;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;

    assign outstanding_o  = r_count;
    assign spurious_rsp_o = r_spurious;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lock      <= 1'b0;
            r_sel       <= 1'b0;
            r_last_data <= 1'b0;
            r_spurious  <= 1'b0;
        end else begin
            r_lock <= w_req & ~mem_gnt_i;
            if (w_req) begin
                r_sel <= w_sel;
            end
            if (w_gnt) begin
                r_last_data <= w_sel;
            end
            if (mem_rvalid_i && w_empty) begin
                r_spurious <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_owner <= '0;
        end else begin
            if (w_push) begin
                r_owner[r_wptr] <= w_sel;
                r_wptr <= (r_wptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed table-driven bench for mem_bus_arbiter; a second instance covers round-robin mode.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'hF;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_err_i = 1'b0;

    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [1:0]  outstanding_o;
    logic        spurious_rsp_o;

    logic        rr_instr_gnt, rr_instr_rvalid, rr_instr_err;
    logic [31:0] rr_instr_rdata;
    logic        rr_data_gnt, rr_data_rvalid, rr_data_err;
    logic [31:0] rr_data_rdata;
    logic        rr_mem_req, rr_mem_we;
    logic [3:0]  rr_mem_be;
    logic [31:0] rr_mem_addr, rr_mem_wdata;
    logic [1:0]  rr_outstanding;
    logic        rr_spurious;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(1'b1)) u_dut (
        .clk(clk), .rstn(rstn),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .outstanding_o(outstanding_o), .spurious_rsp_o(spurious_rsp_o)
    );

    mem_bus_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(1'b0)) u_rr (
        .clk(clk), .rstn(rstn),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(rr_instr_gnt),
        .instr_rvalid_o(rr_instr_rvalid), .instr_rdata_o(rr_instr_rdata),
        .instr_err_o(rr_instr_err),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(rr_data_gnt),
        .data_rvalid_o(rr_data_rvalid), .data_rdata_o(rr_data_rdata), .data_err_o(rr_data_err),
        .mem_req_o(rr_mem_req), .mem_we_o(rr_mem_we), .mem_be_o(rr_mem_be),
        .mem_addr_o(rr_mem_addr), .mem_wdata_o(rr_mem_wdata), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .outstanding_o(rr_outstanding), .spurious_rsp_o(rr_spurious)
    );

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        e_req;
        logic        e_ig;
        logic        e_dg;
        logic        e_irv;
        logic        e_drv;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [1:0]  e_out;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(
        input logic ireq, input logic [31:0] iaddr, input logic dreq, input logic dwe,
        input logic [3:0] dbe, input logic [31:0] daddr, input logic [31:0] dwdata,
        input logic gnt, input logic rv, input logic [31:0] rdata, input logic err,
        input logic e_req, input logic e_ig, input logic e_dg, input logic e_irv,
        input logic e_drv, input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_be,
        input logic [31:0] e_wdata, input logic [1:0] e_out);
        vec_t v;
        v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe; v.dbe = dbe;
        v.daddr = daddr; v.dwdata = dwdata; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.err = err; v.e_req = e_req; v.e_ig = e_ig; v.e_dg = e_dg; v.e_irv = e_irv;
        v.e_drv = e_drv; v.e_addr = e_addr; v.e_we = e_we; v.e_be = e_be;
        v.e_wdata = e_wdata; v.e_out = e_out;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                         input logic dwe, input logic [3:0] dbe, input logic [31:0] daddr,
                         input logic [31:0] dwdata, input logic gnt, input logic rv,
                         input logic [31:0] rdata, input logic err);
        instr_req_i = ireq; instr_addr_i = iaddr; data_req_i = dreq; data_we_i = dwe;
        data_be_i = dbe; data_addr_i = daddr; data_wdata_i = dwdata; mem_gnt_i = gnt;
        mem_rvalid_i = rv; mem_rdata_i = rdata; mem_err_i = err;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 4'hF, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        // ireq iaddr dreq dwe dbe daddr dwdata gnt rv rdata err |
        // req ig dg irv drv addr we be wdata out
        vecs[0]  = mk(1, 32'h100, 0, 1, 4'h5, 32'h0, 32'hAAAA5555, 1, 0, 32'h0, 0,
                      1, 1, 0, 0, 0, 32'h100, 0, 4'hF, 32'h0, 2'd0);
        vecs[1]  = mk(0, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0, 0, 0, 32'h0, 0,
                      0, 0, 0, 0, 0, 32'h0, 0, 4'hF, 32'h0, 2'd1);
        vecs[2]  = mk(0, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0, 0, 1, 32'hDEADBEEF, 0,
                      0, 0, 0, 1, 0, 32'h0, 0, 4'hF, 32'h0, 2'd1);
        vecs[3]  = mk(0, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0, 0, 0, 32'h0, 0,
                      0, 0, 0, 0, 0, 32'h0, 0, 4'hF, 32'h0, 2'd0);
        vecs[4]  = mk(1, 32'h200, 1, 0, 4'hF, 32'h300, 32'h0, 1, 0, 32'h0, 0,
                      1, 0, 1, 0, 0, 32'h300, 0, 4'hF, 32'h0, 2'd0);
        vecs[5]  = mk(1, 32'h200, 1, 0, 4'hF, 32'h300, 32'h0, 1, 1, 32'h11111111, 0,
                      1, 0, 1, 0, 1, 32'h300, 0, 4'hF, 32'h0, 2'd1);
        vecs[6]  = mk(1, 32'h240, 0, 1, 4'h5, 32'h300, 32'hAAAA5555, 1, 1, 32'h22222222, 0,
                      1, 1, 0, 0, 1, 32'h240, 0, 4'hF, 32'h0, 2'd1);
        vecs[7]  = mk(0, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0, 0, 1, 32'h33333333, 0,
                      0, 0, 0, 1, 0, 32'h0, 0, 4'hF, 32'h0, 2'd1);
        vecs[8]  = mk(1, 32'h400, 0, 0, 4'hF, 32'h0, 32'h0, 0, 0, 32'h0, 0,
                      1, 0, 0, 0, 0, 32'h400, 0, 4'hF, 32'h0, 2'd0);
        vecs[9]  = mk(1, 32'h400, 1, 1, 4'h3, 32'h500, 32'h55, 0, 0, 32'h0, 0,
                      1, 0, 0, 0, 0, 32'h400, 0, 4'hF, 32'h0, 2'd0);
        vecs[10] = mk(1, 32'h400, 1, 1, 4'h3, 32'h500, 32'h55, 1, 0, 32'h0, 0,
                      1, 1, 0, 0, 0, 32'h400, 0, 4'hF, 32'h0, 2'd0);
        vecs[11] = mk(0, 32'h0, 1, 1, 4'h3, 32'h500, 32'h55, 1, 0, 32'h0, 0,
                      1, 0, 1, 0, 0, 32'h500, 1, 4'h3, 32'h55, 2'd1);
        vecs[12] = mk(1, 32'h600, 1, 0, 4'hF, 32'h700, 32'h0, 1, 0, 32'h0, 0,
                      0, 0, 0, 0, 0, 32'h0, 0, 4'hF, 32'h0, 2'd2);
        vecs[13] = mk(1, 32'h600, 1, 0, 4'hF, 32'h700, 32'h0, 1, 1, 32'h44, 0,
                      0, 0, 0, 1, 0, 32'h0, 0, 4'hF, 32'h0, 2'd2);
        vecs[14] = mk(0, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0, 0, 1, 32'h55, 0,
                      0, 0, 0, 0, 1, 32'h0, 0, 4'hF, 32'h0, 2'd1);
        vecs[15] = mk(0, 32'h0, 1, 1, 4'h3, 32'h800, 32'h1234, 1, 0, 32'h0, 0,
                      1, 0, 1, 0, 0, 32'h800, 1, 4'h3, 32'h1234, 2'd0);
        vecs[16] = mk(0, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0, 0, 1, 32'h0, 1,
                      0, 0, 0, 0, 1, 32'h0, 0, 4'hF, 32'h0, 2'd1);
        vecs[17] = mk(0, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0, 0, 0, 32'h0, 0,
                      0, 0, 0, 0, 0, 32'h0, 0, 4'hF, 32'h0, 2'd0);

        // Requests presented during reset must not leak out.
        drive(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, '0, 1'b1, 1'b1, '0, 1'b0);
        #2;
        check("reset_mem_req", 32'(mem_req_o), 32'd0);
        check("reset_gnts", {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
        check("reset_rvalids", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
        check("reset_outstanding", 32'(outstanding_o), 32'd0);
        check("reset_spurious", 32'(spurious_rsp_o), 32'd0);
        @(negedge clk);
        idle();
        rstn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe, vecs[i].dbe,
                  vecs[i].daddr, vecs[i].dwdata, vecs[i].gnt, vecs[i].rv, vecs[i].rdata,
                  vecs[i].err);
            #1;
            check($sformatf("v%0d_mem_req", i), 32'(mem_req_o), 32'(vecs[i].e_req));
            check($sformatf("v%0d_instr_gnt", i), 32'(instr_gnt_o), 32'(vecs[i].e_ig));
            check($sformatf("v%0d_data_gnt", i), 32'(data_gnt_o), 32'(vecs[i].e_dg));
            check($sformatf("v%0d_instr_rvalid", i), 32'(instr_rvalid_o), 32'(vecs[i].e_irv));
            check($sformatf("v%0d_data_rvalid", i), 32'(data_rvalid_o), 32'(vecs[i].e_drv));
            check($sformatf("v%0d_outstanding", i), 32'(outstanding_o), 32'(vecs[i].e_out));
            check($sformatf("v%0d_instr_rdata", i), instr_rdata_o, vecs[i].rdata);
            check($sformatf("v%0d_data_rdata", i), data_rdata_o, vecs[i].rdata);
            check($sformatf("v%0d_errs", i), {30'd0, instr_err_o, data_err_o},
                  {30'd0, vecs[i].err, vecs[i].err});
            check($sformatf("v%0d_spurious", i), 32'(spurious_rsp_o), 32'd0);
            if (vecs[i].e_req) begin
                check($sformatf("v%0d_mem_addr", i), mem_addr_o, vecs[i].e_addr);
                check($sformatf("v%0d_mem_we", i), 32'(mem_we_o), 32'(vecs[i].e_we));
                check($sformatf("v%0d_mem_be", i), 32'(mem_be_o), 32'(vecs[i].e_be));
                check($sformatf("v%0d_mem_wdata", i), mem_wdata_o, vecs[i].e_wdata);
            end
        end

        // Response with nothing outstanding is dropped and flagged stickily.
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0, 4'hF, '0, '0, 1'b0, 1'b1, 32'h99, 1'b0);
        #1;
        check("spur_instr_rvalid", 32'(instr_rvalid_o), 32'd0);
        check("spur_data_rvalid", 32'(data_rvalid_o), 32'd0);
        @(negedge clk);
        idle();
        #1;
        check("spur_flag_set", 32'(spurious_rsp_o), 32'd1);
        @(negedge clk);
        #1;
        check("spur_flag_sticky", 32'(spurious_rsp_o), 32'd1);

        // Two in flight, then asynchronous reset mid-cycle.
        @(negedge clk);
        drive(1'b1, 32'h900, 1'b0, 1'b0, 4'hF, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, 1'b1, 1'b0, 4'hF, 32'hA00, '0, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'hB00, 1'b1, 1'b0, 4'hF, 32'hC00, '0, 1'b1, 1'b0, '0, 1'b0);
        #1;
        check("pre_reset_outstanding", 32'(outstanding_o), 32'd2);
        #1;
        rstn = 1'b0;
        #1;
        check("async_reset_outstanding", 32'(outstanding_o), 32'd0);
        check("async_reset_spurious", 32'(spurious_rsp_o), 32'd0);
        check("async_reset_mem_req", 32'(mem_req_o), 32'd0);
        check("async_reset_gnts", {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
        @(negedge clk);
        idle();
        rstn = 1'b1;

        // Continuous contention: fixed priority always data, round-robin alternates from data.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b1, 32'hD00, 1'b1, 1'b0, 4'hF, 32'hE00, '0, 1'b1, (k > 0), 32'(k), 1'b0);
            #1;
            check($sformatf("prio_c%0d_data_gnt", k), 32'(data_gnt_o), 32'd1);
            check($sformatf("prio_c%0d_instr_gnt", k), 32'(instr_gnt_o), 32'd0);
            check($sformatf("rr_c%0d_data_gnt", k), 32'(rr_data_gnt), 32'((k % 2) == 0));
            check($sformatf("rr_c%0d_instr_gnt", k), 32'(rr_instr_gnt), 32'((k % 2) == 1));
            check($sformatf("rr_c%0d_mem_addr", k), rr_mem_addr,
                  ((k % 2) == 0) ? 32'hE00 : 32'hD00);
            check($sformatf("rr_c%0d_data_rvalid", k), 32'(rr_data_rvalid),
                  32'((k % 2) == 1));
            check($sformatf("rr_c%0d_instr_rvalid", k), 32'(rr_instr_rvalid),
                  32'((k > 0) && ((k % 2) == 0)));
        end
        @(negedge clk);
        drive(1'b1, 32'hD00, 1'b0, 1'b0, 4'hF, '0, '0, 1'b1, 1'b1, '0, 1'b0);
        #1;
        check("prio_data_dropped_instr_gnt", 32'(instr_gnt_o), 32'd1);
        @(negedge clk);
        idle();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
